// File: rtl/fanout_load_collector.sv
// ---------------------------------------------------------------------------
// fanout_load_collector
//
// Purpose:
//   Sits on the far end of one high-fanout broadcast net. After a start
//   pulse it captures NUM_LOADS consecutive samples of bcast_d into a bank of
//   capture registers. Each register loads from the same broadcast net. The
//   block also counts the ones. It then offers the bank and the count on a
//   valid/ready handshake.
//
// Ports:
//   clk1       in   1          single clock, rising edge
//   rst_n      in   1          asynchronous active-low reset
//   bcast_d    in   1          broadcast data bit, sampled during CAPTURE
//   start      in   1          begin a frame; honoured only in IDLE
//   out_ready  in   1          consumer accepts the frame (VALID only)
//   busy       out  1          registered, high in CAPTURE or VALID
//   out_valid  out  1          frame available
//   out_data   out  NUM_LOADS  captured bank, bit 0 = first sample
//   out_ones   out  CNT_W      number of ones in out_data
//   out_parity out  1          XOR of out_data (only when
//                              FANOUT_LOAD_COLLECTOR_PARITY_EN is defined)
//
// Optional feature macro: FANOUT_LOAD_COLLECTOR_PARITY_EN
// ---------------------------------------------------------------------------
module fanout_load_collector #(
   parameter int NUM_LOADS = 35,
   parameter int CNT_W     = 6
) (
   input  logic                 clk1,
   input  logic                 rst_n,
   input  logic                 bcast_d,
   input  logic                 start,
   input  logic                 out_ready,
   output logic                 busy,
   output logic                 out_valid,
   output logic [NUM_LOADS-1:0] out_data,
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
   output logic [CNT_W-1:0]     out_ones,
   output logic                 out_parity
`else
   output logic [CNT_W-1:0]     out_ones
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_VALID   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_LOADS - 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       idx_q, idx_d;
   logic [CNT_W-1:0]       ones_q, ones_d;
   logic [NUM_LOADS-1:0]   data_q, data_d;
   logic                   busy_q, busy_d;
   logic                   valid_q, valid_d;
   logic                   cap_en;
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
   logic                   parity_q, parity_d;
`endif

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      ones_d   = ones_q;
      cap_en   = 1'b0;
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d  = ST_CAPTURE;
               idx_d    = '0;
               ones_d   = '0;
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
               parity_d = 1'b0;
`endif
            end
         end
         ST_CAPTURE: begin
            cap_en = 1'b1;
            // Upper bound NUM_LOADS fits in CNT_W bits, so the count never wraps.
            idx_d  = idx_q + 1'b1;
            ones_d = ones_q + {{(CNT_W-1){1'b0}}, bcast_d};
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
            parity_d = parity_q ^ bcast_d;
`endif
            if (idx_q == LAST_IDX) begin
               state_d = ST_VALID;
            end
         end
         ST_VALID: begin
            // A start in the accepting cycle is not seen: the FSM only
            // looks at start while it is in IDLE.
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // busy and out_valid are registered copies of the next state. They
      // therefore line up exactly with state_q.
      busy_d  = (state_d != ST_IDLE);
      valid_d = (state_d == ST_VALID);
   end

   // One load-enable per capture register, decoded from the sample index.
   // Every register takes its D input from the same broadcast net.
   // Bits not yet written in this frame keep their old value.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_LOADS; gi++) begin : g_bank
         assign data_d[gi] = (cap_en && (idx_q == CNT_W'(gi))) ? bcast_d : data_q[gi];
      end
   endgenerate

   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         ones_q   <= '0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         ones_q   <= ones_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign busy      = busy_q;
   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_ones  = ones_q;
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
   assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_fanout_load_collector.sv
// ---------------------------------------------------------------------------
// tb_fanout_load_collector
//
// Purpose:
//   Self-checking bench for fanout_load_collector. It runs these scenarios:
//     - reset
//     - a table of directed frames
//     - backpressure
//     - reset in the middle of a capture
//     - level-held start
//
// Ports: none (top-level bench).
// Optional macro: FANOUT_LOAD_COLLECTOR_PARITY_EN enables the parity checks.
// ---------------------------------------------------------------------------
module tb_fanout_load_collector;

   localparam int N = 35;
   localparam int W = 6;

   logic          clk1 = 1'b0;
   logic          rst_n;
   logic          bcast_d;
   logic          start;
   logic          out_ready;
   logic          busy;
   logic          out_valid;
   logic [N-1:0]  out_data;
   logic [W-1:0]  out_ones;
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
   logic          out_parity;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk1 = ~clk1;

   fanout_load_collector #(.NUM_LOADS(N), .CNT_W(W)) dut (
      .clk1      (clk1),
      .rst_n     (rst_n),
      .bcast_d   (bcast_d),
      .start     (start),
      .out_ready (out_ready),
      .busy      (busy),
      .out_valid (out_valid),
      .out_data  (out_data),
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
      .out_ones  (out_ones),
      .out_parity(out_parity)
`else
      .out_ones  (out_ones)
`endif
   );

   typedef struct {
      string         name;
      logic [N-1:0]  pattern;   // bit i is driven as sample i
      int            hold;      // cycles of out_ready=0 after valid
      logic [W-1:0]  exp_ones;
      logic          exp_par;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic check_frame(input string name, input logic [N-1:0] exp_data,
                              input logic [W-1:0] exp_ones, input logic exp_par);
      check({name, ".valid"}, 64'(out_valid), 64'd1);
      check({name, ".data"},  64'(out_data),  64'(exp_data));
      check({name, ".ones"},  64'(out_ones),  64'(exp_ones));
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
      check({name, ".parity"}, 64'(out_parity), 64'(exp_par));
`else
      if (exp_par === 1'bx) check({name, ".par_tbl"}, 64'd0, 64'd1);
`endif
   endtask

   // Run one frame from IDLE; all drives and samples happen on the falling edge.
   task automatic run_frame(input string name, input logic [N-1:0] pat, input int hold,
                            input logic [W-1:0] exp_ones, input logic exp_par);
      @(negedge clk1);
      start = 1'b1; out_ready = 1'b0;
      @(negedge clk1);                       // start edge k has passed
      start = 1'b0;
      check({name, ".busy"}, 64'(busy), 64'd1);
      for (int i = 0; i < N; i++) begin
         bcast_d = pat[i];
         if (i == N - 1) check({name, ".early_valid"}, 64'(out_valid), 64'd0);
         if (i == 5) start = 1'b1;           // start during CAPTURE must be ignored
         if (i == 6) start = 1'b0;
         @(negedge clk1);
      end
      bcast_d = ~pat[0];                     // out of CAPTURE, must not matter
      check_frame(name, pat, exp_ones, exp_par);
      for (int h = 0; h < hold; h++) begin
         start = (h == 2);
         @(negedge clk1);
         check_frame({name, ".hold"}, pat, exp_ones, exp_par);
      end
      out_ready = 1'b1;
      start     = 1'b1;                      // start in the accepting cycle is ignored
      @(negedge clk1);
      start     = 1'b0;
      out_ready = 1'b0;
      check({name, ".acc_valid"}, 64'(out_valid), 64'd0);
      check({name, ".acc_busy"},  64'(busy),      64'd0);
      @(negedge clk1);
      check({name, ".no_requeue"}, 64'(busy), 64'd0);
      check({name, ".data_kept"},  64'(out_data), 64'(pat));
   endtask

   initial begin
      int cnt;
      vecs[0] = '{"all_ones",  35'h7_FFFF_FFFF, 0,  6'd35, 1'b1};
      vecs[1] = '{"alt",       35'h5_5555_5555, 0,  6'd18, 1'b0};
      vecs[2] = '{"bp_zero",   35'h0_0000_0000, 10, 6'd0,  1'b0};
      vecs[3] = '{"first_bit", 35'h0_0000_0001, 3,  6'd1,  1'b1};
      vecs[4] = '{"last_bit",  35'h4_0000_0000, 0,  6'd1,  1'b1};
      vecs[5] = '{"mid16",     35'h0_FFFF_0000, 10, 6'd16, 1'b0};

      // Reset with active-looking inputs
      rst_n = 1'b0; bcast_d = 1'b1; start = 1'b1; out_ready = 1'b0;
      repeat (3) @(negedge clk1);
      check("rst.busy",  64'(busy),      64'd0);
      check("rst.valid", 64'(out_valid), 64'd0);
      check("rst.data",  64'(out_data),  64'd0);
      check("rst.ones",  64'(out_ones),  64'd0);
`ifdef FANOUT_LOAD_COLLECTOR_PARITY_EN
      check("rst.parity", 64'(out_parity), 64'd0);
`endif
      start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk1);
      check("rst.idle", 64'(busy), 64'd0);

      for (int v = 0; v < 6; v++) begin
         run_frame(vecs[v].name, vecs[v].pattern, vecs[v].hold, vecs[v].exp_ones, vecs[v].exp_par);
         $display("frame %s data=0x%0h ones=%0d", vecs[v].name, out_data, out_ones);
      end

      // Reset after 20 samples of ones
      @(negedge clk1);
      start = 1'b1;
      @(negedge clk1);
      start = 1'b0; bcast_d = 1'b1;
      repeat (20) @(negedge clk1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst.busy",  64'(busy),      64'd0);
      check("midrst.valid", 64'(out_valid), 64'd0);
      check("midrst.data",  64'(out_data),  64'd0);
      check("midrst.ones",  64'(out_ones),  64'd0);
      @(negedge clk1);
      rst_n = 1'b1;
      @(negedge clk1);
      check("midrst.idle", 64'(busy), 64'd0);
      run_frame("zeros_after_rst", 35'h0, 0, 6'd0, 1'b0);
      $display("frame zeros_after_rst data=0x%0h ones=%0d", out_data, out_ones);

      // Level-held start with an always-ready consumer
      bcast_d = 1'b1; out_ready = 1'b1; start = 1'b1;
      cnt = 0;
      while (!out_valid && cnt < 100) begin
         @(negedge clk1);
         cnt++;
      end
      check("lvl.first_valid", 64'(out_valid), 64'd1);
      @(negedge clk1);                       // accept edge has passed
      check("lvl.idle_gap", 64'(busy), 64'd0);
      @(negedge clk1);                       // CAPTURE entry edge has passed
      check("lvl.reenter", 64'(busy), 64'd1);
      cnt = 0;
      while (!out_valid && cnt < 100) begin
         @(negedge clk1);
         cnt++;
      end
      check("lvl.latency", 64'(cnt), 64'(N));
      check("lvl.ones",    64'(out_ones), 64'd35);
      start = 1'b0;
      @(negedge clk1);
      out_ready = 1'b0;
      check("lvl.stop", 64'(out_valid), 64'd0);
      $display("level start latency=%0d", cnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fanout_load_collector.md
Name: fanout_load_collector

Overview:
- Downstream consumer of a single high-fanout broadcast net, such as one flop Q driving 35 D-pin loads.
- Serially captures NUM_LOADS consecutive samples of the broadcast bit into a load bank.
- Counts the ones, then presents the bank and the count on a valid/ready output handshake.
- Used as a timing/fanout-repair test stage: every capture register loads from the same broadcast net.

Parameters:
- NUM_LOADS, 35, number of capture registers and samples per frame (legal range 2..63).
- CNT_W, 6, width of the ones counter and the sample index; must satisfy 2^CNT_W > NUM_LOADS.

Ports:
- clk1  input  1  single clock; all flops rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- bcast_d  input  1  high-fanout broadcast data bit, sampled during CAPTURE.
- start  input  1  begin a frame; honoured only in IDLE.
- out_ready  input  1  consumer accepts the frame.
- busy  output  1  high in CAPTURE or VALID.
- out_valid  output  1  frame available.
- out_data  output  NUM_LOADS  captured bank; bit 0 holds the first sample.
- out_ones  output  CNT_W  number of ones in out_data.

Behaviour:
- Reset (async assert, sync deassert by the upstream reset synchronizer):
  - state=IDLE.
  - busy=0, out_valid=0, out_data=0, out_ones=0, sample index=0.
- IDLE:
  - start=1 at edge k → CAPTURE at edge k, index cleared to 0, ones counter cleared to 0.
  - out_data keeps the previous frame until overwritten.
- CAPTURE:
  - Each edge writes bcast_d into out_data[index] and adds bcast_d to the counter.
  - Index increments on each edge.
  - Samples are taken at edges k+1 .. k+NUM_LOADS.
  - On the edge that writes index NUM_LOADS-1 → VALID.
  - out_valid is visible after edge k+NUM_LOADS (latency: NUM_LOADS cycles from start).
- VALID:
  - out_valid=1; out_data and out_ones held stable while out_ready=0.
  - out_valid=1 and out_ready=1 at an edge → IDLE; out_valid drops after that edge.
  - Back-to-back frames: a start asserted in the same cycle as the accepting handshake is ignored. A new frame needs start while in IDLE, giving a minimum of 1 idle cycle between frames.
- start:
  - Ignored in CAPTURE and VALID; no queuing.
  - A level-high start re-triggers from IDLE on each visit.
- out_ready: ignored outside VALID.
- Counter arithmetic: unsigned CNT_W bits; the maximum value NUM_LOADS never wraps.
- Bank clearing: bits not yet written in a frame retain old values during CAPTURE. All bits are overwritten before VALID.
- Reset mid-frame: returns immediately to IDLE with all outputs cleared; the partial frame is discarded.
- busy = (state != IDLE), registered.

Optional Feature:
- Macro: FANOUT_LOAD_COLLECTOR_PARITY_EN.
- When defined:
  - Adds output out_parity (1 bit) = XOR of out_data, accumulated during CAPTURE and registered.
  - Cleared to 0 on reset and at frame start.
  - Valid and stable alongside out_valid.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 with bcast_d=1 and start=1 → busy=0, out_valid=0, out_data=0, out_ones=0. Release → IDLE.
- All-ones frame: start pulse, bcast_d=1 for 35 cycles, out_ready=1 → out_valid rises exactly 35 cycles after the start edge, out_data=all-ones (35'h7_FFFF_FFFF), out_ones=35. Parity (if enabled)=1.
- Alternating frame: bcast_d=1,0,1,... starting with 1 → out_data bit i = (i even), out_ones=18, parity=0.
- Backpressure: out_ready=0 for 10 cycles after valid → out_valid, out_data and out_ones stable. out_ready=1 → IDLE next edge; start pulses during CAPTURE/VALID produce no extra frame.
- Reset mid-capture: assert rst_n=0 after 20 samples → outputs zero immediately. The next full frame of 35 zeros gives out_ones=0 and out_data=0.
- Level start: start tied high → frames repeat with exactly 1 IDLE cycle between the accept edge and the next CAPTURE entry.
